// File: rtl/dispatch_ctrl_if.sv
// Decoder/back-end dispatch bundle: slot attributes and free counts in,
// per-slot dispatch grants and the fetch-buffer consume count out.
interface dispatch_ctrl_if #(
    parameter int NUM_SUPER = 2,
    parameter int CNT_W     = 6
);
    logic                 dec_valid;
    logic [NUM_SUPER-1:0] slot_halt;
    logic [NUM_SUPER-1:0] slot_illegal;
    logic [NUM_SUPER-1:0] slot_dest_nz;
    logic [NUM_SUPER-1:0] slot_rd_mem;
    logic [NUM_SUPER-1:0] slot_wr_mem;
    logic [CNT_W-1:0]     rob_free;
    logic [CNT_W-1:0]     rs_free;
    logic [CNT_W-1:0]     fl_free;
    logic [CNT_W-1:0]     sq_free;
    logic [CNT_W-1:0]     lq_free;
    logic [NUM_SUPER-1:0] dispatch_en;
    logic [1:0]           fb_take;

    modport master (
        output dec_valid, slot_halt, slot_illegal, slot_dest_nz, slot_rd_mem, slot_wr_mem,
        output rob_free, rs_free, fl_free, sq_free, lq_free,
        input  dispatch_en, fb_take
    );

    modport slave (
        input  dec_valid, slot_halt, slot_illegal, slot_dest_nz, slot_rd_mem, slot_wr_mem,
        input  rob_free, rs_free, fl_free, sq_free, lq_free,
        output dispatch_en, fb_take
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// In-order dispatch admission against ROB/RS/FL/SQ/LQ free counts, with a
// RUN/HALT_PEND/HALTED drain FSM and a saturating stall-cycle counter.
module dispatch_ctrl #(
    parameter int NUM_SUPER = 2,
    parameter int CNT_W     = 6,
    parameter int STALL_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    dispatch_ctrl_if.slave     dif,
    input  logic               rollback,
    input  logic               retire_halt,
    output logic               halt_pending,
    output logic               halted,
    output logic               illegal_seen,
    output logic [STALL_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

    state_t               state;
    logic [NUM_SUPER-1:0] fits;
    logic [NUM_SUPER-1:0] en;
    logic [1:0]           take;
    logic [CNT_W:0]       acc_rob, acc_rs, acc_fl, acc_sq, acc_lq;
    logic                 run;
    logic                 stop_disp;
    logic                 ill_disp;
    logic                 stall_inc;

    function automatic logic [CNT_W:0] zext(input logic b);
        return {{CNT_W{1'b0}}, b};
    endfunction

    assign run = (state == RUN);

    // Cumulative need is one bit wider than the counts so a full structure
    // (all-ones free count) never wraps the comparison.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        acc_rob = '0;
        acc_rs  = '0;
        acc_fl  = '0;
        acc_sq  = '0;
        acc_lq  = '0;
        fits    = '0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            acc_rob = acc_rob + zext(1'b1);
            acc_rs  = acc_rs  + zext(!(dif.slot_halt[i] || dif.slot_illegal[i]));
            acc_fl  = acc_fl  + zext(dif.slot_dest_nz[i] && !dif.slot_illegal[i]);
            acc_sq  = acc_sq  + zext(dif.slot_wr_mem[i]);
            acc_lq  = acc_lq  + zext(dif.slot_rd_mem[i]);
            fits[i] = (acc_rob <= {1'b0, dif.rob_free}) &&
                      (acc_rs  <= {1'b0, dif.rs_free})  &&
                      (acc_fl  <= {1'b0, dif.fl_free})  &&
                      (acc_sq  <= {1'b0, dif.sq_free})  &&
                      (acc_lq  <= {1'b0, dif.lq_free});
        end
    end

    // Reset gates the grants too, so nothing dispatches while reset is held.
    always_comb begin
        en    = '0;
        take  = '0;
        en[0] = reset && run && dif.dec_valid && !rollback && fits[0];
        for (int i = 1; i < NUM_SUPER; i++) begin
            en[i] = en[i-1] && fits[i] && !dif.slot_halt[i-1] && !dif.slot_illegal[i-1];
        end
        for (int i = 0; i < NUM_SUPER; i++) begin
            take = take + {1'b0, en[i]};
        end
    end

    assign dif.dispatch_en = en;
    assign dif.fb_take     = take;

    assign stop_disp = |(en & (dif.slot_halt | dif.slot_illegal));
    assign ill_disp  = |(en & dif.slot_illegal);
    assign stall_inc = run && dif.dec_valid && !rollback && !en[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            halt_pending <= 1'b0;
            halted       <= 1'b0;
            illegal_seen <= 1'b0;
            stall_cycles <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            if (ill_disp) illegal_seen <= 1'b1;
            if (stall_inc && !(&stall_cycles)) stall_cycles <= stall_cycles + STALL_W'(1);
            case (state)
                RUN: begin
                    if (stop_disp) begin
                        state        <= HALT_PEND;
                        halt_pending <= 1'b1;
                    end
                end
                HALT_PEND: begin
                    if (retire_halt) begin
                        state        <= HALTED;
                        halt_pending <= 1'b0;
                        halted       <= 1'b1;
                    end else if (rollback) begin
                        state        <= RUN;
                        halt_pending <= 1'b0;
                    end
                end
                HALTED: ;
                default: begin
                    state        <= RUN;
                    halt_pending <= 1'b0;
                    halted       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: resource limits, halt/illegal draining,
// stall counting and asynchronous reset.
module tb_dispatch_ctrl;
    logic        clock;
    logic        reset;
    logic        rollback;
    logic        retire_halt;
    logic        halt_pending;
    logic        halted;
    logic        illegal_seen;
    logic [31:0] stall_cycles;
    int          n_cmp;
    int          n_bad;

    dispatch_ctrl_if #(.NUM_SUPER(2), .CNT_W(6)) dif ();

    dispatch_ctrl #(.NUM_SUPER(2), .CNT_W(6), .STALL_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .dif          (dif.slave),
        .rollback     (rollback),
        .retire_halt  (retire_halt),
        .halt_pending (halt_pending),
        .halted       (halted),
        .illegal_seen (illegal_seen),
        .stall_cycles (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // retire_halt must only arrive while a halt is pending (or already halted).
    always @(negedge clock) begin
        if (reset) assert (!(retire_halt && !halt_pending && !halted))
            else $error("retire_halt asserted in RUN");
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic defaults();
        dif.dec_valid    = 1'b0;
        dif.slot_halt    = 2'b00;
        dif.slot_illegal = 2'b00;
        dif.slot_dest_nz = 2'b00;
        dif.slot_rd_mem  = 2'b00;
        dif.slot_wr_mem  = 2'b00;
        dif.rob_free     = 6'd8;
        dif.rs_free      = 6'd8;
        dif.fl_free      = 6'd8;
        dif.sq_free      = 6'd8;
        dif.lq_free      = 6'd8;
        rollback         = 1'b0;
        retire_halt      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        defaults();
        dif.dec_valid = 1'b1;
        reset = 1'b0;
        #1;
        if (dif.dispatch_en !== 2'b00) begin n_bad++; $display("FAIL rst_en got %b want 00", dif.dispatch_en); end n_cmp++;
        if (dif.fb_take !== 2'd0) begin n_bad++; $display("FAIL rst_take got %0d want 0", dif.fb_take); end n_cmp++;
        if (halt_pending !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL rst_fsm got hp=%b h=%b want 0 0", halt_pending, halted); end n_cmp++;
        if (illegal_seen !== 1'b0) begin n_bad++; $display("FAIL rst_ill got %b want 0", illegal_seen); end n_cmp++;
        if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_stall got %0d want 0", stall_cycles); end n_cmp++;
        dif.dec_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_full_dispatch();
        defaults();
        dif.dec_valid    = 1'b1;
        dif.slot_dest_nz = 2'b11;
        #1;
        if (dif.dispatch_en !== 2'b11) begin n_bad++; $display("FAIL full_en got %b want 11", dif.dispatch_en); end n_cmp++;
        if (dif.fb_take !== 2'd2) begin n_bad++; $display("FAIL full_take got %0d want 2", dif.fb_take); end n_cmp++;
        tick();
        if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL full_stall got %0d want 0", stall_cycles); end n_cmp++;
    endtask

    task automatic test_fl_limit();
        defaults();
        dif.dec_valid    = 1'b1;
        dif.slot_dest_nz = 2'b11;
        dif.fl_free      = 6'd1;
        #1;
        if (dif.dispatch_en !== 2'b01) begin n_bad++; $display("FAIL fl_en got %b want 01", dif.dispatch_en); end n_cmp++;
        if (dif.fb_take !== 2'd1) begin n_bad++; $display("FAIL fl_take got %0d want 1", dif.fb_take); end n_cmp++;
        tick();
        dif.rob_free = 6'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (dif.dispatch_en !== 2'b00) begin n_bad++; $display("FAIL rob0_en cyc %0d got %b want 00", c, dif.dispatch_en); end n_cmp++;
            tick();
        end
        if (stall_cycles !== 32'd3) begin n_bad++; $display("FAIL rob0_stall got %0d want 3", stall_cycles); end n_cmp++;
    endtask

    task automatic test_mem_limits();
        defaults();
        dif.dec_valid   = 1'b1;
        dif.slot_wr_mem = 2'b11;
        dif.sq_free     = 6'd1;
        #1;
        if (dif.dispatch_en !== 2'b01) begin n_bad++; $display("FAIL sq1_en got %b want 01", dif.dispatch_en); end n_cmp++;
        dif.slot_wr_mem = 2'b10;
        dif.sq_free     = 6'd0;
        #1;
        if (dif.dispatch_en !== 2'b01) begin n_bad++; $display("FAIL sq0_en got %b want 01", dif.dispatch_en); end n_cmp++;
        defaults();
        dif.dec_valid   = 1'b1;
        dif.slot_rd_mem = 2'b01;
        dif.lq_free     = 6'd0;
        #1;
        if (dif.dispatch_en !== 2'b00) begin n_bad++; $display("FAIL lq0_en got %b want 00", dif.dispatch_en); end n_cmp++;
        {dif.rob_free, dif.rs_free, dif.fl_free, dif.sq_free, dif.lq_free} = '1;
        dif.slot_dest_nz = 2'b11;
        dif.slot_rd_mem  = 2'b11;
        #1;
        if (dif.dispatch_en !== 2'b11) begin n_bad++; $display("FAIL max_en got %b want 11", dif.dispatch_en); end n_cmp++;
        {dif.rob_free, dif.rs_free, dif.fl_free, dif.sq_free, dif.lq_free} = '0;
        #1;
        if (dif.dispatch_en !== 2'b00 || dif.fb_take !== 2'd0) begin n_bad++; $display("FAIL zero_en got %b/%0d want 00/0", dif.dispatch_en, dif.fb_take); end n_cmp++;
        defaults();
        #1;
    endtask

    task automatic test_halt();
        defaults();
        dif.dec_valid    = 1'b1;
        dif.slot_halt    = 2'b01;
        dif.slot_dest_nz = 2'b11;
        #1;
        if (dif.dispatch_en !== 2'b01 || dif.fb_take !== 2'd1) begin n_bad++; $display("FAIL halt_en got %b/%0d want 01/1", dif.dispatch_en, dif.fb_take); end n_cmp++;
        tick();
        if (halt_pending !== 1'b1 || halted !== 1'b0) begin n_bad++; $display("FAIL halt_pend got hp=%b h=%b want 1 0", halt_pending, halted); end n_cmp++;
        dif.slot_halt = 2'b00;
        #1;
        if (dif.dispatch_en !== 2'b00) begin n_bad++; $display("FAIL hp_block got %b want 00", dif.dispatch_en); end n_cmp++;
        rollback = 1'b1;
        tick();
        if (halt_pending !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL hp_rollback got hp=%b h=%b want 0 0", halt_pending, halted); end n_cmp++;
        rollback = 1'b0;
        dif.slot_halt = 2'b01;
        #1;
        if (dif.dispatch_en !== 2'b01) begin n_bad++; $display("FAIL halt2_en got %b want 01", dif.dispatch_en); end n_cmp++;
        tick();
        if (halt_pending !== 1'b1) begin n_bad++; $display("FAIL halt2_pend got %b want 1", halt_pending); end n_cmp++;
        dif.slot_halt = 2'b00;
        dif.dec_valid = 1'b0;
        retire_halt   = 1'b1;
        tick();
        if (halted !== 1'b1 || halt_pending !== 1'b0) begin n_bad++; $display("FAIL retire got hp=%b h=%b want 0 1", halt_pending, halted); end n_cmp++;
        retire_halt   = 1'b0;
        dif.dec_valid = 1'b1;
        #1;
        if (dif.dispatch_en !== 2'b00) begin n_bad++; $display("FAIL halted_en got %b want 00", dif.dispatch_en); end n_cmp++;
        rollback = 1'b1;
        tick();
        if (halted !== 1'b1) begin n_bad++; $display("FAIL halted_sticky got %b want 1", halted); end n_cmp++;
        if (stall_cycles !== 32'd3) begin n_bad++; $display("FAIL halted_stall got %0d want 3", stall_cycles); end n_cmp++;
        defaults();
    endtask

    task automatic test_illegal();
        defaults();
        do_reset();
        if (halted !== 1'b0 || stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset2 got h=%b stall=%0d want 0 0", halted, stall_cycles); end n_cmp++;
        dif.dec_valid    = 1'b1;
        dif.slot_illegal = 2'b10;
        dif.slot_dest_nz = 2'b11;
        dif.rs_free      = 6'd1;
        #1;
        if (dif.dispatch_en !== 2'b11 || dif.fb_take !== 2'd2) begin n_bad++; $display("FAIL ill_en got %b/%0d want 11/2", dif.dispatch_en, dif.fb_take); end n_cmp++;
        tick();
        if (illegal_seen !== 1'b1 || halt_pending !== 1'b1) begin n_bad++; $display("FAIL ill_seen got ill=%b hp=%b want 1 1", illegal_seen, halt_pending); end n_cmp++;
        defaults();
        rollback    = 1'b1;
        retire_halt = 1'b1;
        tick();
        if (halted !== 1'b1 || illegal_seen !== 1'b1) begin n_bad++; $display("FAIL both_win got h=%b ill=%b want 1 1", halted, illegal_seen); end n_cmp++;
        defaults();
    endtask

    task automatic test_reset_mid_halt();
        defaults();
        do_reset();
        dif.dec_valid = 1'b1;
        dif.rob_free  = 6'd0;
        tick();
        if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL mid_stall got %0d want 1", stall_cycles); end n_cmp++;
        dif.rob_free     = 6'd8;
        dif.slot_illegal = 2'b01;
        #1;
        if (dif.dispatch_en !== 2'b01) begin n_bad++; $display("FAIL ill0_en got %b want 01", dif.dispatch_en); end n_cmp++;
        tick();
        if (halt_pending !== 1'b1 || illegal_seen !== 1'b1) begin n_bad++; $display("FAIL mid_hp got hp=%b ill=%b want 1 1", halt_pending, illegal_seen); end n_cmp++;
        dif.slot_illegal = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        if (dif.dispatch_en !== 2'b00 || dif.fb_take !== 2'd0) begin n_bad++; $display("FAIL async_en got %b/%0d want 00/0", dif.dispatch_en, dif.fb_take); end n_cmp++;
        if (halt_pending !== 1'b0 || halted !== 1'b0 || illegal_seen !== 1'b0 || stall_cycles !== 32'd0) begin
            n_bad++; $display("FAIL async_regs got hp=%b h=%b ill=%b stall=%0d want 0 0 0 0", halt_pending, halted, illegal_seen, stall_cycles);
        end n_cmp++;
        #1;
        reset = 1'b1;
        #1;
        if (dif.dispatch_en !== 2'b11 || dif.fb_take !== 2'd2) begin n_bad++; $display("FAIL post_rst_en got %b/%0d want 11/2", dif.dispatch_en, dif.fb_take); end n_cmp++;
        tick();
        if (halt_pending !== 1'b0 || stall_cycles !== 32'd0) begin n_bad++; $display("FAIL post_rst_regs got hp=%b stall=%0d want 0 0", halt_pending, stall_cycles); end n_cmp++;
        defaults();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_full_dispatch();
        test_fl_limit();
        test_mem_limits();
        test_halt();
        test_illegal();
        test_reset_mid_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
